spike_flit_serializer: RTL and testbench

- Neuron-side transmit path of the local port.
- Accepts 32-bit spike packets from the Neuron, buffers them in a small packet FIFO, and serialises each packet into 4-bit flits.
- Flits go into the router local input (local_in / write_en_local), honouring the router's local full flag.
- This is the counterpart of the interface block, which reassembles local_out flits into packets and spikes.

---
 rtl/noc_pkg.sv | 31 +++
 rtl/sync_packet_fifo.sv | 51 +++++
 rtl/spike_flit_serializer.sv | 127 ++++++++++++
 tb/tb_spike_flit_serializer.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/noc_pkg.sv
// Shared NoC definitions for the neuron-side local port.
//   DEFAULT_PACKET_SIZE / DEFAULT_FLIT_SIZE : default packet and flit widths
//   DEST_X_MSB / DEST_Y_MSB / PAYLOAD_MSB   : spike packet header field offsets
//   tx_state_t                              : serializer state encoding
//   make_packet()                           : assemble a spike packet from its fields
package noc_pkg;

   localparam int DEFAULT_PACKET_SIZE = 32;
   localparam int DEFAULT_FLIT_SIZE   = 4;

   localparam int DEST_X_MSB  = 31;
   localparam int DEST_Y_MSB  = 23;
   localparam int PAYLOAD_MSB = 15;

   typedef enum logic {
      IDLE = 1'b0,
      SEND = 1'b1
   } tx_state_t;

   function automatic logic [31:0] make_packet(input logic [7:0]  dest_x,
                                               input logic [7:0]  dest_y,
                                               input logic [15:0] payload);
      logic [31:0] pkt;
      pkt = '0;
      pkt[DEST_X_MSB -: 8]   = dest_x;
      pkt[DEST_Y_MSB -: 8]   = dest_y;
      pkt[PAYLOAD_MSB -: 16] = payload;
      return pkt;
   endfunction

endpackage

// File: rtl/sync_packet_fifo.sv
// Single-clock packet FIFO with first-word-fall-through read data.
//   clk, rst_n : clock, async active-low reset (empties the FIFO)
//   wr_en      : push wr_data (ignored when full)
//   rd_en      : pop head (ignored when empty); rd_data always shows the head
//   count      : entries held, 0..DEPTH
//   empty/full : status from registered pointers
module sync_packet_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 4,
   localparam int AW   = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             wr_en,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             rd_en,
   output logic [WIDTH-1:0] rd_data,
   output logic [AW:0]      count,
   output logic             empty,
   output logic             full
);

   logic [WIDTH-1:0] mem [DEPTH];
   // extra MSB on each pointer separates full from empty when the indices match
   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic             do_wr;
   logic             do_rd;

   assign count   = wr_ptr - rd_ptr;
   assign empty   = (count == '0);
   assign full    = (count == (AW+1)'(DEPTH));
   assign do_wr   = wr_en && !full;
   assign do_rd   = rd_en && !empty;
   assign rd_data = mem[rd_ptr[AW-1:0]];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_wr) wr_ptr <= wr_ptr + 1'b1;
         if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (do_wr) mem[wr_ptr[AW-1:0]] <= wr_data;
   end

endmodule

// File: rtl/spike_flit_serializer.sv
// Neuron-side transmit path: buffers spike packets and serialises each one
// into flits (most-significant flit first) for the router local input.
//   clk, rst_n    : neuron clock, async active-low reset
//   packet_in     : spike packet {dest X, dest Y, axon payload}
//   packet_valid  : write request, one packet per high cycle
//   packet_ready  : FIFO has a free slot this cycle
//   flit_out      : flit to router local_in (0 when not sending)
//   wr_req_out    : flit write strobe to router write_en_local
//   router_full   : router local input buffer full
//   busy          : packets queued or a packet in flight
//   drop_cnt      : saturating count of packets offered while full
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | no packet in flight; loads the FIFO head when one exists
// SEND  | shift_reg holds the packet, top flit presented to router
module spike_flit_serializer
   import noc_pkg::*;
#(
   parameter int PACKET_SIZE    = DEFAULT_PACKET_SIZE,
   parameter int FLIT_SIZE      = DEFAULT_FLIT_SIZE,
   parameter int FIFO_DEPTH     = 4,
   parameter int DROP_CNT_WIDTH = 8
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [PACKET_SIZE-1:0]    packet_in,
   input  logic                      packet_valid,
   output logic                      packet_ready,
   output logic [FLIT_SIZE-1:0]      flit_out,
   output logic                      wr_req_out,
   input  logic                      router_full,
   output logic                      busy,
   output logic [DROP_CNT_WIDTH-1:0] drop_cnt
);

   localparam int NUM_FLITS = PACKET_SIZE / FLIT_SIZE;
   localparam int CW        = (NUM_FLITS > 1) ? $clog2(NUM_FLITS) : 1;
   localparam int FAW       = $clog2(FIFO_DEPTH);
   localparam logic [CW-1:0] LAST_FLIT = CW'(NUM_FLITS - 1);

   tx_state_t              state;
   tx_state_t              state_nxt;
   logic [PACKET_SIZE-1:0] shift_reg;
   logic [CW-1:0]          flit_cnt;
   logic [PACKET_SIZE-1:0] fifo_rd_data;
   logic [FAW:0]           fifo_count;
   logic                   fifo_empty;
   logic                   fifo_full;
   logic                   pop;
   logic                   flit_accept;

   // ready comes from registered occupancy, so a pop never frees a slot
   // for a push in the same cycle
   assign packet_ready = !fifo_full;
   assign busy         = (fifo_count != '0) || (state == SEND);

   sync_packet_fifo #(
      .WIDTH (PACKET_SIZE),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .wr_en   (packet_valid),
      .wr_data (packet_in),
      .rd_en   (pop),
      .rd_data (fifo_rd_data),
      .count   (fifo_count),
      .empty   (fifo_empty),
      .full    (fifo_full)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // wr_req_out gates registered state with router_full only, so a full
   // router never receives a write
   always_comb begin
      state_nxt   = state;
      pop         = 1'b0;
      flit_accept = 1'b0;
      flit_out    = '0;
      case (state)
         IDLE: begin
            if (!fifo_empty) begin
               pop       = 1'b1;
               state_nxt = SEND;
            end
         end
         SEND: begin
            flit_out    = shift_reg[PACKET_SIZE-1 -: FLIT_SIZE];
            flit_accept = !router_full;
            if (flit_accept && (flit_cnt == LAST_FLIT)) begin
               if (!fifo_empty) pop       = 1'b1;
               else             state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign wr_req_out = flit_accept;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shift_reg <= '0;
         flit_cnt  <= '0;
      end else if (pop) begin
         shift_reg <= fifo_rd_data;
         flit_cnt  <= '0;
      end else if (flit_accept) begin
         shift_reg <= shift_reg << FLIT_SIZE;
         flit_cnt  <= flit_cnt + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         drop_cnt <= '0;
      end else if (packet_valid && !packet_ready && (drop_cnt != '1)) begin
         drop_cnt <= drop_cnt + 1'b1;
      end
   end

endmodule

// File: tb/tb_spike_flit_serializer.sv
module tb_spike_flit_serializer;
   import noc_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] packet_in;
   logic        packet_valid;
   logic        packet_ready;
   logic [3:0]  flit_out;
   logic        wr_req_out;
   logic        router_full;
   logic        busy;
   logic [7:0]  drop_cnt;

   int n_checks = 0;
   int n_fail   = 0;

   spike_flit_serializer dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .packet_in    (packet_in),
      .packet_valid (packet_valid),
      .packet_ready (packet_ready),
      .flit_out     (flit_out),
      .wr_req_out   (wr_req_out),
      .router_full  (router_full),
      .busy         (busy),
      .drop_cnt     (drop_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      string       name;
      logic [31:0] pkt;
      logic [7:0][3:0] flits;   // flits[7] leaves first
   } vec_t;

   vec_t vecs[4];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic push(input logic [31:0] p);
      @(negedge clk);
      chk("push_ready", packet_ready, 1'b1);
      packet_in    = p;
      packet_valid = 1'b1;
      @(posedge clk);
      #1 packet_valid = 1'b0;
   endtask

   // One flit accepted every non-stalled cycle, strictly; stall_len cycles of
   // router_full are inserted once stall_after flits have gone.
   task automatic expect_stream(input string nm, input logic [3:0] exp[$],
                                input int stall_after, input int stall_len);
      int acc = 0;
      int st  = 0;
      while (acc < exp.size()) begin
         @(negedge clk);
         if (acc == stall_after && st < stall_len) begin
            router_full = 1'b1;
            st++;
            #1;
            chk({nm, "_stall_wr"}, wr_req_out, 1'b0);
            chk({nm, "_stall_flit"}, flit_out, exp[acc]);
         end else begin
            router_full = 1'b0;
            #1;
            chk({nm, "_wr"}, wr_req_out, 1'b1);
            chk({nm, "_flit"}, flit_out, exp[acc]);
            acc++;
         end
      end
   endtask

   task automatic idle_check(input string nm);
      @(negedge clk);
      #1;
      chk({nm, "_idle_wr"}, wr_req_out, 1'b0);
      chk({nm, "_idle_busy"}, busy, 1'b0);
      chk({nm, "_idle_flit"}, flit_out, 4'h0);
   endtask

   task automatic first_gap(input string nm);
      @(negedge clk);
      #1;
      chk({nm, "_latency_wr"}, wr_req_out, 1'b0);
      chk({nm, "_latency_busy"}, busy, 1'b1);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [3:0]  exp_q[$];
      logic [31:0] drop_pk[6];
      logic        exp_ready[6];

      rst_n        = 1'b0;
      packet_in    = '0;
      packet_valid = 1'b0;
      router_full  = 1'b0;

      vecs[0].name = "v0102abcd"; vecs[0].pkt = make_packet(8'h01, 8'h02, 16'hABCD);
      vecs[0].flits = {4'h0, 4'h1, 4'h0, 4'h2, 4'hA, 4'hB, 4'hC, 4'hD};
      vecs[1].name = "vffff0000"; vecs[1].pkt = make_packet(8'hFF, 8'hFF, 16'h0000);
      vecs[1].flits = {4'hF, 4'hF, 4'hF, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0};
      vecs[2].name = "v80000001"; vecs[2].pkt = make_packet(8'h80, 8'h00, 16'h0001);
      vecs[2].flits = {4'h8, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h1};
      vecs[3].name = "v5a5ac3c3"; vecs[3].pkt = make_packet(8'h5A, 8'h5A, 16'hC3C3);
      vecs[3].flits = {4'h5, 4'hA, 4'h5, 4'hA, 4'hC, 4'h3, 4'hC, 4'h3};

      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("rst_flit", flit_out, 4'h0);
      chk("rst_wr", wr_req_out, 1'b0);
      chk("rst_ready", packet_ready, 1'b1);
      chk("rst_busy", busy, 1'b0);
      chk("rst_drop", drop_cnt, 8'h00);

      // single packets with latency check
      for (int v = 0; v < 4; v++) begin
         exp_q = {};
         for (int k = 7; k >= 0; k--) exp_q.push_back(vecs[v].flits[k]);
         push(vecs[v].pkt);
         first_gap(vecs[v].name);
         expect_stream(vecs[v].name, exp_q, -1, 0);
         idle_check(vecs[v].name);
      end

      // router_full for 3 cycles after the 3rd flit
      push(make_packet(8'h03, 8'h00, 16'h5EED));
      first_gap("stall");
      exp_q = '{4'h0, 4'h3, 4'h0, 4'h0, 4'h5, 4'hE, 4'hE, 4'hD};
      expect_stream("stall", exp_q, 3, 3);
      idle_check("stall");

      // back-to-back packets; second push coincides with IDLE loading the first
      push(make_packet(8'h01, 8'h02, 16'hABCD));
      push(make_packet(8'h3C, 8'h4D, 16'h9E2F));
      exp_q = '{4'h0, 4'h1, 4'h0, 4'h2, 4'hA, 4'hB, 4'hC, 4'hD,
                4'h3, 4'hC, 4'h4, 4'hD, 4'h9, 4'hE, 4'h2, 4'hF};
      expect_stream("b2b", exp_q, -1, 0);
      idle_check("b2b");

      // FIFO fill with router stalled, drops and saturation
      exp_ready = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
      @(negedge clk);
      router_full = 1'b1;
      for (int i = 0; i < 6; i++) begin
         drop_pk[i] = make_packet(8'(8'h10 + i), 8'(8'h20 + i), 16'(16'hC0DE + i));
         @(negedge clk);
         chk($sformatf("fill_ready_%0d", i), packet_ready, exp_ready[i]);
         packet_in    = drop_pk[i];
         packet_valid = 1'b1;
      end
      @(negedge clk);
      packet_valid = 1'b0;
      #1;
      chk("fill_drop1", drop_cnt, 8'd1);
      chk("fill_ready_after", packet_ready, 1'b0);
      chk("fill_busy", busy, 1'b1);
      chk("fill_wr", wr_req_out, 1'b0);

      packet_in    = 32'hDEAD_BEEF;
      packet_valid = 1'b1;
      repeat (253) @(posedge clk);
      #1 chk("drop_254", drop_cnt, 8'd254);
      @(posedge clk);
      #1 chk("drop_255", drop_cnt, 8'd255);
      repeat (5) @(posedge clk);
      #1 chk("drop_sat", drop_cnt, 8'd255);
      packet_valid = 1'b0;

      exp_q = {};
      for (int i = 0; i < 5; i++)
         for (int k = 7; k >= 0; k--) exp_q.push_back(drop_pk[i][k*4 +: 4]);
      expect_stream("drain", exp_q, -1, 0);
      idle_check("drain");

      // reset after 4 flits of a packet
      push(make_packet(8'h76, 8'h54, 16'h3210));
      first_gap("rstmid");
      exp_q = '{4'h7, 4'h6, 4'h5, 4'h4};
      expect_stream("rstmid", exp_q, -1, 0);
      @(negedge clk);
      #1 rst_n = 1'b0;
      #1;
      chk("rstmid_wr", wr_req_out, 1'b0);
      chk("rstmid_busy", busy, 1'b0);
      chk("rstmid_flit", flit_out, 4'h0);
      chk("rstmid_drop", drop_cnt, 8'd0);
      chk("rstmid_ready", packet_ready, 1'b1);
      @(negedge clk);
      rst_n = 1'b1;
      push(make_packet(8'h9A, 8'hBC, 16'hDEF1));
      first_gap("postrst");
      exp_q = '{4'h9, 4'hA, 4'hB, 4'hC, 4'hD, 4'hE, 4'hF, 4'h1};
      expect_stream("postrst", exp_q, -1, 0);
      idle_check("postrst");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
